// File: rtl/register_file_param.sv
// Parameterised 2-read/1-write register file with optional zero register,
// optional write-to-read forwarding and a one-register-per-cycle clear sweep.
module register_file_param #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              clr,
   output logic              busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  wsel;
   logic              wr_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (clr) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            // Last register of the sweep: return to IDLE rather than wrapping.
            if (cnt == '1) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + ADDR_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      wr_en = we && !busy && !((ZERO_REG != 0) && (waddr == '0));
      wsel  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         wsel[i] = wr_en && (waddr == ADDR_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (busy && (cnt == ADDR_W'(i))) begin
               mem[i] <= '0;
            end else if (wsel[i]) begin
               mem[i] <= wdata;
            end
         end
      end
   end

   // Zero register wins over forwarding; forwarding only follows effective writes.
   always_comb begin
      rdata1 = mem[raddr1];
      rdata2 = mem[raddr2];
      if ((BYPASS != 0) && wr_en && (waddr == raddr1)) rdata1 = wdata;
      if ((BYPASS != 0) && wr_en && (waddr == raddr2)) rdata2 = wdata;
      if ((ZERO_REG != 0) && (raddr1 == '0)) rdata1 = '0;
      if ((ZERO_REG != 0) && (raddr2 == '0)) rdata2 = '0;
   end

endmodule
